// File: rtl/servo_cmd_pkg.sv
// servo_cmd_pkg: shared constants, FSM state encoding and frame validation
// helper for the servo command sequencer.
package servo_cmd_pkg;

    localparam logic [7:0] HDR_BYTE     = 8'hA5;
    localparam logic [7:0] ACK_BYTE     = 8'h06;
    localparam logic [7:0] NAK_BYTE     = 8'h15;
    localparam logic [7:0] ANGLE_MAX    = 8'd180;
    localparam logic [7:0] ANGLE_CENTER = 8'd90;

    typedef enum logic [2:0] {
        IDLE,
        GET_CH,
        GET_ANG,
        GET_CS,
        SEND,
        WAIT_TX
    } state_t;

    // A frame is accepted only with a matching checksum, an existing channel
    // and an angle inside the servo's mechanical range.
    function automatic logic frame_valid(input logic [7:0]  ch,
                                         input logic [7:0]  ang,
                                         input logic [7:0]  cs,
                                         input int unsigned n_ch);
        return (cs == (ch ^ ang)) && (32'(ch) < n_ch) && (ang <= ANGLE_MAX);
    endfunction

endpackage

// File: rtl/servo_slew.sv
// servo_slew: one channel's target/current angle registers.
// With SERVO_SLEW_EN defined the current angle walks toward the target by at
// most STEP_DEG per frame tick; otherwise the written angle is applied at once.
module servo_slew
    import servo_cmd_pkg::*;
`ifdef SERVO_SLEW_EN
#(
    parameter int STEP_DEG = 2
)
`endif
(
    input  logic       clk,
    input  logic       rst,
`ifdef SERVO_SLEW_EN
    input  logic       tick,
`endif
    input  logic       wr_en,
    input  logic [7:0] wr_ang,
    output logic [7:0] angle,
    output logic       busy
);

`ifdef SERVO_SLEW_EN
    localparam logic [7:0] STEP = 8'(STEP_DEG);

    logic [7:0] tgt;

    // Target write and per-tick slew; a same-cycle write is seen by the next
    // tick only, because the slew compares against the pre-edge target.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tgt   <= ANGLE_CENTER;
            angle <= ANGLE_CENTER;
        end else begin
            if (wr_en)
                tgt <= wr_ang;
            if (tick) begin
                // Compare first so the subtraction below never wraps.
                if (angle < tgt)
                    angle <= ((tgt - angle) > STEP) ? (angle + STEP) : tgt;
                else if (angle > tgt)
                    angle <= ((angle - tgt) > STEP) ? (angle - STEP) : tgt;
            end
        end
    end

    assign busy = (angle != tgt);
`else
    // Without slewing the target is the output angle itself.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            angle <= ANGLE_CENTER;
        else if (wr_en)
            angle <= wr_ang;
    end

    assign busy = 1'b0;
`endif

endmodule

// File: rtl/servo_cmd_sequencer.sv
// servo_cmd_sequencer: parses A5/CH/ANG/CS frames from the UART RX path,
// updates per-channel servo targets and answers each frame with ACK or NAK.
// Optional feature macro: SERVO_SLEW_EN (frame-rate slew limiting).
module servo_cmd_sequencer
    import servo_cmd_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int CLK_HZ      = 50000000,
    parameter int FRAME_HZ    = 50,
    parameter int STEP_DEG    = 2,
    parameter int TIMEOUT_CYC = 5000000
)(
    input  logic              Clk,
    input  logic              Rst,
    input  logic [7:0]        RxData,
    input  logic              RxDone,
    output logic [7:0]        TxData,
    output logic              TxStart,
    input  logic              TxDone,
    output logic [8*N_CH-1:0] Angle,
    output logic              Busy,
    output logic [7:0]        ErrCnt
);

    // Elaboration-time parameter sanity checks.
    if (N_CH < 1 || N_CH > 8) begin : g_bad_nch
        $error("N_CH must be 1..8");
    end
    if (STEP_DEG < 1 || STEP_DEG > 180) begin : g_bad_step
        $error("STEP_DEG must be 1..180");
    end
    if (FRAME_HZ < 1 || CLK_HZ < 2 * FRAME_HZ) begin : g_bad_frame
        $error("CLK_HZ/FRAME_HZ must be at least 2");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_to
        $error("TIMEOUT_CYC must be at least 1");
    end

    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    state_t            state;
    logic [7:0]        ch_q;
    logic [7:0]        ang_q;
    logic [TO_W-1:0]   to_cnt;
    logic              timeout;
    logic              frame_ok;
    logic              wr_en;
    logic [N_CH-1:0]   busy_ch;

    assign timeout  = (to_cnt == TO_W'(TIMEOUT_CYC - 1));
    assign frame_ok = frame_valid(ch_q, ang_q, RxData, N_CH);
    // Target registers latch on the edge that samples the CS byte.
    assign wr_en    = (state == GET_CS) && RxDone && frame_ok;

    // Frame parser, response generation, error counter and inter-byte timer.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state   <= IDLE;
            ch_q    <= '0;
            ang_q   <= '0;
            to_cnt  <= '0;
            TxData  <= 8'h00;
            TxStart <= 1'b0;
            ErrCnt  <= 8'h00;
        end else begin
            TxStart <= 1'b0;
            case (state)
                IDLE: begin
                    to_cnt <= '0;
                    if (RxDone && RxData == HDR_BYTE)
                        state <= GET_CH;
                end
                GET_CH: if (RxDone) begin
                    ch_q  <= RxData;
                    state <= GET_ANG;
                end
                GET_ANG: if (RxDone) begin
                    ang_q <= RxData;
                    state <= GET_CS;
                end
                GET_CS: if (RxDone) begin
                    if (frame_ok) begin
                        TxData <= ACK_BYTE;
                    end else begin
                        TxData <= NAK_BYTE;
                        if (ErrCnt != 8'hFF)
                            ErrCnt <= ErrCnt + 8'd1;
                    end
                    // Raised here so it is high for exactly the SEND cycle.
                    TxStart <= 1'b1;
                    state   <= SEND;
                end
                SEND:    state <= WAIT_TX;
                WAIT_TX: if (TxDone) state <= IDLE;
                default: state <= IDLE;
            endcase

            // A stalled partial frame is abandoned silently; any byte restarts the timer.
            if (state == GET_CH || state == GET_ANG || state == GET_CS) begin
                if (RxDone) begin
                    to_cnt <= '0;
                end else if (timeout) begin
                    to_cnt <= '0;
                    state  <= IDLE;
                end else begin
                    to_cnt <= to_cnt + 1'b1;
                end
            end
        end
    end

`ifdef SERVO_SLEW_EN
    localparam int FRAME_DIV = CLK_HZ / FRAME_HZ;
    localparam int FC_W      = $clog2(FRAME_DIV);

    logic [FC_W-1:0] frame_cnt;
    logic            tick;

    assign tick = (frame_cnt == FC_W'(FRAME_DIV - 1));

    // Free-running servo frame counter; tick marks the wrap cycle.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst)
            frame_cnt <= '0;
        else if (tick)
            frame_cnt <= '0;
        else
            frame_cnt <= frame_cnt + 1'b1;
    end
`endif

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        logic wr_ch;
        assign wr_ch = wr_en && (ch_q == 8'(k));
`ifdef SERVO_SLEW_EN
        servo_slew #(
            .STEP_DEG (STEP_DEG)
        ) u_slew (
            .clk    (Clk),
            .rst    (Rst),
            .tick   (tick),
            .wr_en  (wr_ch),
            .wr_ang (ang_q),
            .angle  (Angle[8*k +: 8]),
            .busy   (busy_ch[k])
        );
`else
        servo_slew u_slew (
            .clk    (Clk),
            .rst    (Rst),
            .wr_en  (wr_ch),
            .wr_ang (ang_q),
            .angle  (Angle[8*k +: 8]),
            .busy   (busy_ch[k])
        );
`endif
    end

    assign Busy = |busy_ch;

endmodule

// File: doc/servo_cmd_sequencer.md
Name: servo_cmd_sequencer

Overview:
Command controller between the UART receiver/transmitter and the per-channel servo PWM generators. It parses framed byte commands from the RX path and validates them. Accepted angles are written into per-channel target registers, and each channel's output angle is slewed toward its target once per 20 ms servo frame. Every frame is answered with an ACK or NAK byte through the TX path.

Parameters:
N_CH, 4, number of servo channels (1..8)
CLK_HZ, 50000000, Clk frequency in Hz
FRAME_HZ, 50, servo frame rate; slew updates occur once per frame
STEP_DEG, 2, maximum angle change per frame per channel (1..180)
TIMEOUT_CYC, 5000000, inter-byte timeout in Clk cycles (100 ms)

Ports:
Clk  in  1  system clock
Rst  in  1  asynchronous reset, active-high
RxData  in  8  received byte; valid only while RxDone=1
RxDone  in  1  single-cycle pulse, one per received byte
TxData  out  8  response byte; held stable from TxStart until TxDone
TxStart  out  1  single-cycle request to transmit TxData
TxDone  in  1  single-cycle pulse when the transmitter has sent the byte
Angle  out  8*N_CH  current angle per channel, 0..180; channel k occupies bits [8k+7:8k]
Busy  out  1  high while any channel has current angle != target angle
ErrCnt  out  8  count of NAKed frames; saturates at 255

Behaviour:
- Reset (async, Rst=1): all current and target angles = 90; TxData=0x00; TxStart=0; Busy=0; ErrCnt=0; FSM=IDLE; frame counter=0.
- Frame format: 0xA5 header, CH, ANG, CS, where CS must equal CH ^ ANG.
- FSM states: IDLE, GET_CH, GET_ANG, GET_CS, SEND, WAIT_TX.
  - IDLE: on RxDone with byte 0xA5, go to GET_CH. Any other byte is silently discarded.
  - GET_CH / GET_ANG / GET_CS: each state latches the byte on RxDone and advances to the next state.
  - Inter-byte timeout: if no RxDone arrives within TIMEOUT_CYC cycles, return to IDLE silently. No response is sent and ErrCnt does not change. The timer restarts on every RxDone.
  - Validation at GET_CS, on the cycle the CS byte arrives. The frame is valid only if CS matches, CH < N_CH and ANG <= 180.
  - Valid frame: write the target register of channel CH on the next cycle and load TxData=0x06 (ACK).
  - Invalid frame: targets are unchanged, TxData=0x15 (NAK) and ErrCnt increments (saturating at 255).
  - From GET_CS go to SEND.
  - SEND: assert TxStart for exactly one cycle, then go to WAIT_TX.
  - WAIT_TX: on TxDone go to IDLE. RxDone bytes arriving in SEND or WAIT_TX are dropped.
- Frame tick: a counter wraps at CLK_HZ/FRAME_HZ-1 (999999 at the defaults) and produces a one-cycle tick at the wrap. The counter runs freely and is independent of the FSM.
- Slew: on each tick, every channel whose current angle differs from its target moves toward the target by min(STEP_DEG, |target-current|). The step never overshoots; arithmetic is unsigned 8-bit with a compare before subtract.
- Simultaneous target write and tick on the same channel: the slew uses the old target. The new target takes effect from the next tick.
- Angle is registered. Its latency from a tick is 1 cycle.
- Busy is combinational OR of (current != target) across all channels.
- Reset mid-frame or mid-slew: everything is reinitialised to the reset values above. A TxStart pulse already issued is not retracted.

Optional Feature:
SERVO_SLEW_EN
- Defined: slew behaviour as described above.
- Undefined: current angle = target angle, updated in the same cycle as the target write. Angle therefore changes 1 cycle after the CS byte is accepted. The frame tick counter and STEP_DEG are unused, and Busy is tied to 0.

Decomposition:
- Package servo_cmd_pkg holds:
  - constants HDR_BYTE=0xA5, ACK_BYTE=0x06, NAK_BYTE=0x15, ANGLE_MAX=180, ANGLE_CENTER=90;
  - the FSM state enumeration.
- Sub-module servo_slew: one channel's current/target registers, write port, tick input and step logic. It is instantiated N_CH times by the top block.

Test Plan:
- After reset, frame A5 01 3C 3D (CH=1, ANG=60) -> TxStart pulse with TxData=0x06. Channel 1 target=60. Angle ch1 steps 90→88→86… (2 per tick) and reaches 60 after 15 ticks. Busy=1 during the ramp and falls to 0 after the 15th tick.
- Frame A5 02 C8 CA (ANG=200) -> NAK 0x15, ErrCnt=1, all targets unchanged. Frame A5 07 10 17 (CH=7 with N_CH=4) -> NAK, ErrCnt=2.
- Frame A5 00 5A 00 (bad CS; correct CS is 0x5A) -> NAK 0x15, ErrCnt increments, channel 0 unchanged.
- Send A5 01, then stall for TIMEOUT_CYC+1 cycles, then send 3C 3D -> no TxStart, FSM returns to IDLE, both bytes are discarded as non-header bytes, ErrCnt unchanged.
- Send a valid frame, then send 0xA5 while in WAIT_TX, and pulse TxDone only after 100 cycles -> the extra byte is dropped and exactly one TxStart is seen.
- Build with SERVO_SLEW_EN undefined, send A5 03 B4 B7 -> Angle ch3=180 exactly 1 cycle after the CS byte, and Busy stays 0 throughout.
